// File: rtl/spmv_mem_pkg.sv
// spmv_mem_pkg: shared types and constants for the SpMV memory responder.
// Optional feature macro: SPMV_MEM_RESP_JITTER_EN (LFSR latency jitter).
`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 512
`endif
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 40
`endif

package spmv_mem_pkg;

  localparam int SPMV_LINE_OFFS = 6;
  localparam int SPMV_TRANSID_W = 6;
  localparam int SPMV_IDX_W     = 16;
  localparam int SPMV_TIMER_W   = 8;

  localparam logic [15:0] SPMV_LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] SPMV_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [SPMV_TRANSID_W-1:0] transid;
    logic [SPMV_IDX_W-1:0]     idx;
    logic [SPMV_TIMER_W-1:0]   timer;
  } spmv_mem_req_t;

  function automatic logic [15:0] spmv_lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & SPMV_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spmv_resp_fifo.sv
// spmv_resp_fifo: in-order ring of outstanding line reads with
// per-entry countdown timers; head_ready flags an expired head.
module spmv_resp_fifo
  import spmv_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  spmv_mem_req_t          push_entry,
  input  logic                   pop,
  output spmv_mem_req_t          head,
  output logic                   head_ready,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  spmv_mem_req_t    ent [DEPTH];
  logic [PTR_W-1:0] hd;
  logic [PTR_W-1:0] tl;
  logic [PTR_W:0]   cnt;
  logic [DEPTH-1:0] occ;

  // a slot is live when its distance from head is below count
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = {1'b0, PTR_W'(i) - hd} < cnt;
    end
  end

  // tick live timers toward zero, then apply push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && ent[i].timer != '0) begin
          ent[i].timer <= ent[i].timer - 1'b1;
        end
      end
      if (push) begin
        ent[tl] <= push_entry;
        tl      <= tl + 1'b1;
      end
      if (pop) begin
        hd <= hd + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!push && pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign head       = ent[hd];
  assign head_ready = (cnt != '0) && (ent[hd].timer == '0);
  assign full       = (cnt == (PTR_W+1)'(DEPTH));
  assign count      = cnt;

endmodule

// File: rtl/spmv_mem_responder.sv
// spmv_mem_responder: memory-side model answering SpMV line reads in order
// after a fixed latency. SPMV_MEM_RESP_JITTER_EN adds 0..3 random cycles.
`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 512
`endif
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 40
`endif

module spmv_mem_responder
  import spmv_mem_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LAT       = 4,
  parameter int MEM_WORDS = 1024,
  parameter int DATA_W    = `DCP_NOC_RES_DATA_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_req_val,
  output logic                         mem_req_rdy,
  input  logic [5:0]                   mem_req_transid,
  input  logic [`DCP_PADDR_MASK-1:0]   mem_req_addr,
  output logic                         mem_resp_val,
  output logic [5:0]                   mem_resp_transid,
  output logic [DATA_W-1:0]            mem_resp_data,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [DATA_W-1:0]            load_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0]       mem [MEM_WORDS];
  spmv_mem_req_t           req;
  spmv_mem_req_t           head;
  logic                    accept;
  logic                    pop;
  logic                    head_ready;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  logic [SPMV_TIMER_W-1:0] extra;
  logic [IDX_W-1:0]        head_idx;

  assign mem_req_rdy = !rst && !full;
  assign accept      = mem_req_val && mem_req_rdy;
  assign pop         = head_ready;
  assign head_idx    = head.idx[IDX_W-1:0];

`ifdef SPMV_MEM_RESP_JITTER_EN
  logic [15:0] lfsr;

  // step the jitter source once per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SPMV_LFSR_SEED;
    end else if (accept) begin
      lfsr <= spmv_lfsr_next(lfsr);
    end
  end

  assign extra = {{(SPMV_TIMER_W-2){1'b0}}, lfsr[1:0]};
`else
  assign extra = '0;
`endif

  // the accepting edge counts as the first latency tick, so the
  // stored timer is one less than the wanted latency
  always_comb begin
    req         = '0;
    req.transid = mem_req_transid;
    req.idx     = SPMV_IDX_W'(mem_req_addr[SPMV_LINE_OFFS +: IDX_W]);
    req.timer   = SPMV_TIMER_W'(LAT - 1) + extra;
  end

  spmv_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_entry(req),
    .pop       (pop),
    .head      (head),
    .head_ready(head_ready),
    .full      (full),
    .count     (count)
  );

  // backdoor preload port; contents are never reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  // capture the head line and ID on every pop; pulse valid once
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_resp_val     <= 1'b0;
      mem_resp_transid <= '0;
      mem_resp_data    <= '0;
    end else begin
      mem_resp_val <= pop;
      if (pop) begin
        mem_resp_transid <= head.transid;
        mem_resp_data    <= mem[head_idx];
      end
    end
  end

endmodule

// File: tb/tb_spmv_mem_responder.sv
// tb_spmv_mem_responder: randomized scoreboard bench for the responder.
// LAT is raised to DEPTH so the queue can actually fill.
module tb_spmv_mem_responder;

  localparam int DEPTH     = 8;
  localparam int LAT       = 8;
  localparam int MEM_WORDS = 1024;
  localparam int DATA_W    = 512;
  localparam int AW        = 40;
  localparam int IW        = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_val = 1'b0;
  logic              req_rdy;
  logic [5:0]        req_tid = '0;
  logic [AW-1:0]     req_addr = '0;
  logic              resp_val;
  logic [5:0]        resp_tid;
  logic [DATA_W-1:0] resp_data;
  logic              load_en = 1'b0;
  logic [IW-1:0]     load_idx = '0;
  logic [DATA_W-1:0] load_data = '0;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]        tid;
    logic [DATA_W-1:0] data;
    int                acc;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model_mem [MEM_WORDS];
  int                last_resp = -1000;

  exp_t e;
  int   lo;
  int   hi;
  logic exp_rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spmv_mem_responder #(
    .DEPTH    (DEPTH),
    .LAT      (LAT),
    .MEM_WORDS(MEM_WORDS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_val     (req_val),
    .mem_req_rdy     (req_rdy),
    .mem_req_transid (req_tid),
    .mem_req_addr    (req_addr),
    .mem_resp_val    (resp_val),
    .mem_resp_transid(resp_tid),
    .mem_resp_data   (resp_data),
    .load_en         (load_en),
    .load_idx        (load_idx),
    .load_data       (load_data)
  );

  // monitor: score responses, check rdy, record accepts
  always @(negedge clk) begin
    if (resp_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_resp: got tid %0d at cycle %0d, none expected",
                 resp_tid, cyc);
      end else begin
        e = exp_q.pop_front();
`ifdef SPMV_MEM_RESP_JITTER_EN
        lo = e.acc + LAT;
        hi = (e.acc + LAT + 3 > last_resp + 1) ?
             e.acc + LAT + 3 : last_resp + 1;
`else
        lo = (e.acc + LAT > last_resp + 1) ? e.acc + LAT : last_resp + 1;
        hi = lo;
`endif
        vectors++;
        if (resp_tid !== e.tid) begin
          errors++;
          $display("FAIL resp_tid: got %0d want %0d", resp_tid, e.tid);
        end
        vectors++;
        if (resp_data !== e.data) begin
          errors++;
          $display("FAIL resp_data tid %0d: got %h want %h",
                   e.tid, resp_data, e.data);
        end
        vectors++;
        if (cyc < lo || cyc > hi) begin
          errors++;
          $display("FAIL resp_time tid %0d: got cycle %0d want %0d..%0d",
                   e.tid, cyc, lo, hi);
        end
        last_resp = cyc;
      end
    end
    exp_rdy = !rst && (exp_q.size() != DEPTH);
    vectors++;
    if (req_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL req_rdy at cycle %0d: got %b want %b (queued %0d)",
               cyc, req_rdy, exp_rdy, exp_q.size());
    end
    if (rst) begin
      exp_q.delete();
      last_resp = -1000;
    end else if (req_val && req_rdy) begin
      exp_q.push_back('{tid: req_tid,
                        data: model_mem[req_addr[6 +: IW]],
                        acc: cyc + 1});
    end
  end

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) begin
      v[i*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] tid, input logic [AW-1:0] addr);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    req_val  = 1'b1;
    req_tid  = tid;
    req_addr = addr;
    do begin
      @(negedge clk);
      acc = req_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: tid %0d never accepted", tid);
    end
    req_val = 1'b0;
  endtask

  task automatic load(input int idx, input logic [DATA_W-1:0] d);
    load_en   = 1'b1;
    load_idx  = IW'(idx);
    load_data = d;
    model_mem[idx] = d;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    tick(3);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding want 0",
               exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (resp_val !== 1'b0 || resp_tid !== 6'd0 || resp_data !== '0) begin
      errors++;
      $display("FAIL %s: got val %b tid %0d data %h want all zero",
               tag, resp_val, resp_tid, resp_data);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int            idx;

    tick(3);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;

    for (int i = 0; i < MEM_WORDS; i++) begin
      load(i, rand_line());
    end
    load(3, {16{32'hA5A5A5A5}});

    send(6'd7, AW'(40'hC0));
    drain();

    for (int t = 0; t < 10; t++) begin
      send(6'(t), AW'(t * 64));
    end
    drain();

    for (int k = 1; k < 5; k++) begin
      idx = $urandom_range(0, MEM_WORDS - 1);
      a = AW'((idx + k * MEM_WORDS) * 64 + $urandom_range(0, 63));
      send(6'(k + 20), a);
    end
    drain();

    for (int t = 0; t < 5; t++) begin
      send(6'(t + 40), AW'($urandom_range(0, MEM_WORDS - 1) * 64));
    end
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midop_reset_outputs");
    rst = 1'b0;
    tick(LAT + 8);
    send(6'd33, AW'(5 * 64));
    drain();

    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 3));
      end
      a = AW'({$urandom, $urandom});
      send(6'($urandom), a);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
